// File: rtl/approx_mult_arbiter.sv
// Round-robin arbiter sharing one external combinational approximate 8x8 multiplier
// among four requesters, with a private wrap-around accumulator per requester.
module approx_mult_arbiter #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [7:0]       req_op,
  output logic [3:0]       req_ready,
  output logic [7:0]       mult_a,
  output logic [7:0]       mult_b,
  input  logic [15:0]      mult_p,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic [ACC_W-1:0] rsp_data,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  state_t           state, state_nxt;
  logic [1:0]       last_grant;
  logic [1:0]       grant_id;
  logic             grant_any;
  logic [1:0]       cand;
  logic [7:0]       op_a, op_b;
  logic [1:0]       op_code;
  logic [1:0]       op_id;
  logic [ACC_W-1:0] acc [4];
  logic [ACC_W-1:0] result;

  // Operation result; MAC wraps modulo 2^ACC_W, CLR ignores the product.
  function automatic logic [ACC_W-1:0] op_result(input logic [1:0] op,
                                                 input logic [ACC_W-1:0] acc_cur,
                                                 input logic [15:0] p);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(p);
    case (op)
      OP_MUL:  op_result = ext;
      OP_MAC:  op_result = acc_cur + ext;
      OP_LOAD: op_result = ext;
      default: op_result = '0;
    endcase
  endfunction

  // Search starts one past the last winner and wraps; k==4 lands on last_grant itself.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // req_ready is a Mealy output of IDLE: the accepting edge is the one that leaves IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = 4'b0000;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready = 4'b0001 << grant_id;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) req_ready = 4'b0000;
  end

  assign mult_a = (state == ISSUE) ? op_a : 8'd0;
  assign mult_b = (state == ISSUE) ? op_b : 8'd0;
  assign result = op_result(op_code, acc[op_id], mult_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      op_id      <= 2'd0;
      op_code    <= OP_MUL;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_data   <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        last_grant <= grant_id;
        op_id      <= grant_id;
        op_code    <= req_op[{grant_id, 1'b0} +: 2];
      end
      if (state == ISSUE) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_data  <= result;
        if (op_code != OP_MUL) acc[op_id] <= result;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  // Operand latch carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any) begin
      op_a <= req_a[{grant_id, 3'b000} +: 8];
      op_b <= req_b[{grant_id, 3'b000} +: 8];
    end
  end

endmodule
